// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing source. Produces registered column/row counts,
// active-low HSync/VSync, active-video flag and line/frame start strobes,
// all describing the same pixel position in every cycle.
// Optional feature macro: VGA_SYNC_FRAME_COUNT_EN adds an 8-bit o_Frame_Count.
module vga_sync_gen #(
    parameter int unsigned TOTAL_COLS    = 800,
    parameter int unsigned TOTAL_ROWS    = 525,
    parameter int unsigned ACTIVE_COLS   = 640,
    parameter int unsigned ACTIVE_ROWS   = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_WIDTH  = 96,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_WIDTH  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Line_Start,
    output logic       o_Frame_Start
`ifdef VGA_SYNC_FRAME_COUNT_EN
    ,
    output logic [7:0] o_Frame_Count
`endif
);

    localparam int unsigned CNT_W = 10;
    // One extra bit so window ends up to 1024 compare without truncation.
    localparam int unsigned CMP_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

    localparam logic [CMP_W-1:0] ACT_COLS = CMP_W'(ACTIVE_COLS);
    localparam logic [CMP_W-1:0] ACT_ROWS = CMP_W'(ACTIVE_ROWS);
    localparam logic [CMP_W-1:0] HS_START = CMP_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CMP_W-1:0] HS_END   = CMP_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [CMP_W-1:0] VS_START = CMP_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [CMP_W-1:0] VS_END   = CMP_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_active;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_col_wrap;
    logic [CNT_W-1:0] w_col_next;
    logic [CNT_W-1:0] w_row_next;
    logic [CMP_W-1:0] w_col_cmp;
    logic [CMP_W-1:0] w_row_cmp;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_active_next;
    logic             w_line_start_next;
    logic             w_frame_start_next;

    // Next position and its decoded syncs/strobes, so outputs align with counts.
    always_comb begin
        w_col_wrap         = (r_col == COL_LAST);
        w_col_next         = w_col_wrap ? '0 : r_col + CNT_W'(1);
        w_row_next         = r_row;
        if (w_col_wrap) begin
            w_row_next     = (r_row == ROW_LAST) ? '0 : r_row + CNT_W'(1);
        end
        w_col_cmp          = CMP_W'(w_col_next);
        w_row_cmp          = CMP_W'(w_row_next);
        w_hsync_next       = !((w_col_cmp >= HS_START) && (w_col_cmp < HS_END));
        w_vsync_next       = !((w_row_cmp >= VS_START) && (w_row_cmp < VS_END));
        w_active_next      = (w_col_cmp < ACT_COLS) && (w_row_cmp < ACT_ROWS);
        w_line_start_next  = (w_col_next == '0);
        w_frame_start_next = w_line_start_next && (w_row_next == '0);
    end

    // Position/sync registers: reset parks at the last pixel, enable advances.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_col         <= COL_LAST;
            r_row         <= ROW_LAST;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_Enable) begin
            r_col         <= w_col_next;
            r_row         <= w_row_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_active      <= w_active_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    // Frame counter bumps on the same edge that raises the frame strobe.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_frame_count <= '0;
        end else if (i_Enable && w_frame_start_next) begin
            r_frame_count <= r_frame_count + 8'(1);
        end
    end

    assign o_Frame_Count = r_frame_count;
`endif

    assign o_HSync       = r_hsync;
    assign o_VSync       = r_vsync;
    assign o_Col_Count   = r_col;
    assign o_Row_Count   = r_row;
    assign o_Active      = r_active;
    assign o_Line_Start  = r_line_start;
    assign o_Frame_Start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives a default-timing instance and a small-geometry
// instance from the same stimulus and compares every output each cycle with
// a position model derived from the count of enabled edges since reset.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;

    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_col, s_row;
    logic [7:0] d_fc, s_fc;

    vga_sync_gen u_dflt (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Enable      (en),
        .o_HSync       (d_hs),
        .o_VSync       (d_vs),
        .o_Col_Count   (d_col),
        .o_Row_Count   (d_row),
        .o_Active      (d_act),
        .o_Line_Start  (d_ls),
        .o_Frame_Start (d_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
        ,
        .o_Frame_Count (d_fc)
`endif
    );

    vga_sync_gen #(
        .TOTAL_COLS(16), .TOTAL_ROWS(10), .ACTIVE_COLS(10), .ACTIVE_ROWS(6),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2)
    ) u_small (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Enable      (en),
        .o_HSync       (s_hs),
        .o_VSync       (s_vs),
        .o_Col_Count   (s_col),
        .o_Row_Count   (s_row),
        .o_Active      (s_act),
        .o_Line_Start  (s_ls),
        .o_Frame_Start (s_fs)
`ifdef VGA_SYNC_FRAME_COUNT_EN
        ,
        .o_Frame_Count (s_fc)
`endif
    );

`ifndef VGA_SYNC_FRAME_COUNT_EN
    assign d_fc = 8'h00;
    assign s_fc = 8'h00;
`endif

    int n        = 0;   // enabled edges since last reset edge
    bit en_last  = 1'b0;
    int cyc      = 0;
    int asserts  = 0;
    int fails    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs: position n-1 of the raster in row-major order.
    task automatic check_geom(input string nm,
                              input int C, input int R, input int AC, input int AR,
                              input int HFP, input int HSW, input int VFP, input int VSW,
                              input logic [9:0] col, input logic [9:0] row,
                              input logic hs, input logic vs, input logic act,
                              input logic ls, input logic fs, input logic [7:0] fc);
        int ec, er, ehs, evs, eact, els, efs, efc, p;
        if (n == 0) begin
            ec = C - 1; er = R - 1; ehs = 1; evs = 1; eact = 0; els = 0; efs = 0; efc = 0;
        end else begin
            p    = (n - 1) % (C * R);
            ec   = p % C;
            er   = p / C;
            ehs  = (ec >= AC + HFP && ec < AC + HFP + HSW) ? 0 : 1;
            evs  = (er >= AR + VFP && er < AR + VFP + VSW) ? 0 : 1;
            eact = (ec < AC && er < AR) ? 1 : 0;
            els  = (en_last && ec == 0) ? 1 : 0;
            efs  = (els == 1 && er == 0) ? 1 : 0;
            efc  = ((n - 1) / (C * R) + 1) % 256;
        end
        chk({nm, ".col"},   32'(col), 32'(ec));
        chk({nm, ".row"},   32'(row), 32'(er));
        chk({nm, ".hsync"}, 32'(hs),  32'(ehs));
        chk({nm, ".vsync"}, 32'(vs),  32'(evs));
        chk({nm, ".active"},32'(act), 32'(eact));
        chk({nm, ".lstart"},32'(ls),  32'(els));
        chk({nm, ".fstart"},32'(fs),  32'(efs));
`ifdef VGA_SYNC_FRAME_COUNT_EN
        chk({nm, ".fcount"},32'(fc),  32'(efc));
`else
        if (fc !== 8'h00) chk({nm, ".fcount_tie"}, 32'(fc), 32'(efc));
`endif
    endtask

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        cyc++;
        if (r) begin
            n = 0; en_last = 1'b0;
        end else if (e) begin
            n++; en_last = 1'b1;
        end else begin
            en_last = 1'b0;
        end
        #1;
        check_geom("dflt", 800, 525, 640, 480, 16, 96, 10, 2,
                   d_col, d_row, d_hs, d_vs, d_act, d_ls, d_fs, d_fc);
        check_geom("small", 16, 10, 10, 6, 2, 3, 1, 2,
                   s_col, s_row, s_hs, s_vs, s_act, s_ls, s_fs, s_fc);
    endtask

    initial begin
        int prev;
        int hs_low;
        int frames;
        int k;
        bit ls_prev;
        rst = 1'b1;
        en  = 1'b0;

        // Reset held three cycles: parked position.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("rst.col", 32'(d_col), 32'd799);
        chk("rst.row", 32'(d_row), 32'd524);
        chk("rst.syncs", 32'({d_hs, d_vs, d_act, d_ls, d_fs}), 32'b11000);

        // First enabled edge lands on (0,0) with both strobes.
        step(1'b0, 1'b1);
        chk("first.pos", 32'({d_col, d_row}), 32'd0);
        chk("first.strobes", 32'({d_fs, d_ls, d_act}), 32'b111);

        // Continuous run: HSync width and line period on the default timing.
        prev = 1; hs_low = (d_hs == 1'b0) ? 1 : 0;
        for (int i = 2; i <= 1700; i++) begin
            step(1'b0, 1'b1);
            if (i <= 800 && d_hs == 1'b0) hs_low++;
            if (d_ls) begin
                chk("line.period", 32'(i - prev), 32'd800);
                prev = i;
            end
        end
        chk("hsync.width", 32'(hs_low), 32'd96);

        // Enable toggling: line period doubles, strobes stay single-cycle.
        prev = -1; ls_prev = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            step(1'b0, (i % 2) == 0);
            if (d_ls && ls_prev) chk("strobe.len", 32'(1), 32'(0));
            ls_prev = d_ls;
            if (d_ls) begin
                if (prev >= 0) chk("line.period.gated", 32'(i - prev), 32'd1600);
                prev = i;
            end
        end

        // Random enable with rare random resets.
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0);
        end

        // Mid-frame reset while the small instance is inside both sync pulses.
        k = 0;
        while (!(s_row == 10'd7 && s_col == 10'd13) && k < 400) begin
            step(1'b0, 1'b1);
            k++;
        end
        chk("mid.reach", 32'(k < 400), 32'd1);
        chk("mid.syncs_low", 32'({s_hs, s_vs}), 32'b00);
        step(1'b1, 1'b1);
        chk("mid.park", 32'({s_col, s_row}), 32'({10'd15, 10'd9}));
        chk("mid.syncs_high", 32'({s_hs, s_vs}), 32'b11);
        step(1'b0, 1'b1);
        chk("mid.restart", 32'({s_col, s_row, s_fs, s_ls}), 32'({20'd0, 2'b11}));

        // 257 small frames from reset: frame period and frame count wrap.
        step(1'b1, 1'b0);
        prev = -1; frames = 0;
        for (int i = 0; i < 257 * 160; i++) begin
            step(1'b0, 1'b1);
            if (s_fs) begin
                frames++;
                if (prev >= 0) chk("frame.period", 32'(i - prev), 32'd160);
                prev = i;
            end
        end
        chk("frame.total", 32'(frames), 32'd257);
`ifdef VGA_SYNC_FRAME_COUNT_EN
        chk("fcount.wrap", 32'(s_fc), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA horizontal/vertical sync pulses plus column/row position counts for the display pipeline.
- It is the source end of the sync interface that the sync-to-count stage and the neuron renderer consume.
- Default timing is 640x480 in an 800x525 total frame, with negative-polarity syncs.
- Counts, syncs and strobes are registered and mutually aligned: in any cycle, every output describes the same pixel position.

Parameters:
- TOTAL_COLS, 800, pixels per line including blanking; must be ≤1024.
- TOTAL_ROWS, 525, lines per frame including blanking; must be ≤1024.
- ACTIVE_COLS, 640, visible pixels per line.
- ACTIVE_ROWS, 480, visible lines per frame.
- H_FRONT_PORCH, 16, pixels between end of active video and start of HSync.
- H_SYNC_WIDTH, 96, HSync pulse width in pixels.
- V_FRONT_PORCH, 10, lines between end of active video and start of VSync.
- V_SYNC_WIDTH, 2, VSync pulse width in lines.

Ports:
- i_Clk  input  1  system clock.
- i_Reset  input  1  synchronous, active-high reset.
- i_Enable  input  1  pixel advance enable; tie high when i_Clk is the pixel clock.
- o_HSync  output  1  horizontal sync, active low.
- o_VSync  output  1  vertical sync, active low.
- o_Col_Count  output  10  current column, 0..TOTAL_COLS-1.
- o_Row_Count  output  10  current row, 0..TOTAL_ROWS-1.
- o_Active  output  1  high when col < ACTIVE_COLS and row < ACTIVE_ROWS.
- o_Line_Start  output  1  one-cycle strobe when col advances to 0.
- o_Frame_Start  output  1  one-cycle strobe when position advances to (0,0).

Behaviour:
- Reset: one clock, synchronous, active-high (i_Clk / i_Reset).
- Any edge with i_Reset=1 (overrides i_Enable) loads the parked position:
  - col=TOTAL_COLS-1, row=TOTAL_ROWS-1.
  - o_HSync=1, o_VSync=1, o_Active=0, o_Line_Start=0, o_Frame_Start=0.
- Edge with i_Reset=0, i_Enable=1: advance the position and update all outputs to describe the new position in the same edge. Latency is 0 between count and sync/active.
  - col = (col==TOTAL_COLS-1) ? 0 : col+1.
  - When col wraps: row = (row==TOTAL_ROWS-1) ? 0 : row+1. Otherwise row holds.
- Edge with i_Reset=0, i_Enable=0: position, syncs and o_Active hold; both strobes forced 0.
- Sync decoding from the new position:
  - o_HSync=0 iff ACTIVE_COLS+H_FRONT_PORCH ≤ col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH.
  - o_VSync=0 iff ACTIVE_ROWS+V_FRONT_PORCH ≤ row < ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH.
  - VSync changes only on line boundaries (col=0).
- Strobes, from the new position:
  - o_Line_Start=1 for exactly one cycle when new col==0.
  - o_Frame_Start=1 when new col==0 and row==0; o_Line_Start is also 1 on that cycle.
- First enabled edge after reset goes to (0,0): o_Frame_Start=1, o_Line_Start=1, o_Active=1. The first frame is therefore complete, with no partial frame.
- Reset mid-frame: next edge returns to the parked position regardless of current state. No glitch: syncs go inactive-high immediately.
- Arithmetic: 10-bit unsigned. The next-state compare uses equality to TOTAL-1, so no overflow past TOTAL.
- Frame period at i_Enable=1: exactly TOTAL_COLS*TOTAL_ROWS = 420000 cycles between o_Frame_Start pulses.

Optional Feature:
- Macro: VGA_SYNC_FRAME_COUNT_EN.
- When defined:
  - Adds output o_Frame_Count (8 bits).
  - Reset value 0.
  - Increments on every cycle where o_Frame_Start is asserted; wraps 255→0.
  - The first frame after reset reads 1.
- When undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_Reset 3 cycles → col=799, row=524, o_HSync=1, o_VSync=1, o_Active=0, strobes 0. Release with i_Enable=1 → next cycle col=0, row=0, o_Frame_Start=1, o_Line_Start=1, o_Active=1.
- HSync window: run one line → o_HSync=0 exactly for col 656..751 (96 cycles), 1 elsewhere. o_Active falls when col goes 639→640.
- Wrap and VSync: run a full frame → row increments on the 799→0 transition. o_VSync=0 for rows 490..491 (1600 cycles). o_Frame_Start period is 420000 cycles; o_Line_Start period is 800 cycles.
- Enable gating: toggle i_Enable 1/0 each cycle → counts advance every other cycle, strobes never exceed 1 cycle, line period becomes 1600 clocks.
- Mid-frame reset: assert i_Reset at row 300, col 700 → next edge col=799, row=524, syncs high. The following enabled edge gives (0,0) with o_Frame_Start=1.
- With VGA_SYNC_FRAME_COUNT_EN: run 257 frames from reset → o_Frame_Count goes 1,2,…,255,0,1.
